load_sqn_alloc: RTL

Allocates load sequence numbers (loadSqN) to load uops leaving rename, two slots per cycle, and throttles rename when the load buffer window is exhausted. It sits between rename and the load buffer: it consumes the load buffer's maxLoadSqN, and it rolls its allocation pointer back on branch mispredicts. It is the admission controller that keeps the load buffer from being indexed past its capacity.

---
 rtl/load_sqn_alloc.sv | 95 +++++++++
 1 files changed

// File: rtl/load_sqn_alloc.sv
// load_sqn_alloc
//    Hands out load sequence numbers to load uops leaving rename, two slots
//    per cycle. It stalls rename when the load buffer window cannot take the
//    whole demand, and it reloads its allocation pointer on a mispredict.
//
// Ports
//    clk               clock
//    rst               synchronous, active-high reset
//    IN_valid          per-slot uop valid
//    IN_isLoad         per-slot uop is a load (ignored unless IN_valid)
//    IN_maxLoadSqN     highest loadSqN the load buffer can accept now
//    IN_branchTaken    mispredict / flush this cycle
//    IN_branchLoadSqN  pointer value to restore on flush
//    OUT_stall         combinational; rename holds both slots this cycle
//    OUT_valid         registered; slot i carries an allocated loadSqN
//    OUT_loadSqN0/1    registered loadSqN for slot 0 / slot 1
//    OUT_nextLoadSqN   registered allocation pointer
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal admission; allocate when the demand fits the window
// RECOVER  | one bubble after a flush; stall and allocate nothing
module load_sqn_alloc #(
   parameter int NUM_SLOTS = 2,
   parameter int SQN_W     = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SLOTS-1:0] IN_valid,
   input  logic [NUM_SLOTS-1:0] IN_isLoad,
   input  logic [SQN_W-1:0]     IN_maxLoadSqN,
   input  logic                 IN_branchTaken,
   input  logic [SQN_W-1:0]     IN_branchLoadSqN,
   output logic                 OUT_stall,
   output logic [NUM_SLOTS-1:0] OUT_valid,
   output logic [SQN_W-1:0]     OUT_loadSqN0,
   output logic [SQN_W-1:0]     OUT_loadSqN1,
   output logic [SQN_W-1:0]     OUT_nextLoadSqN
);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_RECOVER = 1'b1;

   logic [0:0]           state;
   logic [SQN_W-1:0]     ptr;
   logic [NUM_SLOTS-1:0] req;
   logic [1:0]           demand;
   logic [SQN_W-1:0]     diff;
   logic                 fits;
   logic                 alloc;

   assign req    = IN_valid & IN_isLoad;
   assign demand = {1'b0, req[0]} + {1'b0, req[1]};

   // Distance of the last requested sqN past the window limit, modulo 2^SQN_W.
   // Reading it as signed stays correct across pointer wrap while the live
   // window is under half the sequence space.
   assign diff = ptr + SQN_W'(demand) - SQN_W'(1) - IN_maxLoadSqN;
   assign fits = (demand == 2'd0) | diff[SQN_W-1] | (diff == '0);

   assign alloc = (state == ST_RUN) & ~IN_branchTaken & fits;

   // A flush stalls even under reset; everything else is masked by reset.
   assign OUT_stall = IN_branchTaken |
                      (~rst & ((state == ST_RECOVER) | ~fits));

   assign OUT_nextLoadSqN = ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         ptr          <= '0;
         OUT_valid    <= '0;
         OUT_loadSqN0 <= '0;
         OUT_loadSqN1 <= '0;
      end else if (IN_branchTaken) begin
         state     <= ST_RECOVER;
         ptr       <= IN_branchLoadSqN;
         OUT_valid <= '0;
      end else if (state == ST_RECOVER) begin
         state     <= ST_RUN;
         OUT_valid <= '0;
      end else if (alloc) begin
         OUT_valid <= req;
         if (demand != 2'd0) begin
            OUT_loadSqN0 <= ptr;
            OUT_loadSqN1 <= ptr + SQN_W'(req[0]);
            ptr          <= ptr + SQN_W'(demand);
         end
      end else begin
         OUT_valid <= '0;
      end
   end

endmodule
